// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: bubble instruction, opcodes used by decode,
// and the fetch FSM state encoding.
package rv_pipe_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack + rvalid bus between fetch and imem.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched instruction while decode is stalled.
import rv_pipe_pkg::*;

module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] ld_pc,
    input  logic [31:0] ld_insn,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] insn
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            insn  <= NOP_INSN;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= ld_pc;
            insn  <= ld_insn;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: single outstanding imem request, stall hold buffer,
// redirect with kill of the in-flight fetch, bubble when nothing is ready.
import rv_pipe_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 keep,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [31:0]          PC_pype0,
    output logic [31:0]          PCp4_pype0,
    output logic [31:0]          Instraction_pype,
    output logic                 fetch_valid
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, req_pc;
    logic         req, acc, rsp_use, hold_load, hold_drain;
    logic         hold_valid;
    logic [31:0]  hold_pc, hold_insn;

    // A new request may overlap the retiring response only when decode takes it directly.
    assign req = !rst && !redirect && !hold_valid &&
                 (state == S_IDLE || (state == S_WAIT && imem.imem_rvalid && !keep));
    assign acc        = req && imem.imem_ack;
    assign rsp_use    = (state == S_WAIT) && imem.imem_rvalid && !redirect;
    assign hold_load  = rsp_use && keep;
    assign hold_drain = hold_valid && !keep && !redirect;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            if (state != S_IDLE)
                state_nxt = imem.imem_rvalid ? S_IDLE : S_KILL;
        end else begin
            case (state)
                S_IDLE:  if (acc) state_nxt = S_WAIT;
                S_WAIT:  if (imem.imem_rvalid) state_nxt = acc ? S_WAIT : S_IDLE;
                S_KILL:  if (imem.imem_rvalid) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (acc) begin
                req_pc <= pc;
                pc     <= pc + 32'd4;
            end
        end
    end

    fetch_hold_buf u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (hold_load),
        .drain   (hold_drain),
        .flush   (redirect),
        .ld_pc   (req_pc),
        .ld_insn (imem.imem_rdata),
        .valid   (hold_valid),
        .pc      (hold_pc),
        .insn    (hold_insn)
    );

    // Redirect beats keep: the bubble is shown even while decode is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_pype0         <= 32'h0;
            PCp4_pype0       <= 32'h0;
            Instraction_pype <= NOP_INSN;
            fetch_valid      <= 1'b0;
        end else if (redirect) begin
            Instraction_pype <= NOP_INSN;
            fetch_valid      <= 1'b0;
        end else if (!keep) begin
            if (hold_valid) begin
                PC_pype0         <= hold_pc;
                PCp4_pype0       <= hold_pc + 32'd4;
                Instraction_pype <= hold_insn;
                fetch_valid      <= 1'b1;
            end else if (rsp_use) begin
                PC_pype0         <= req_pc;
                PCp4_pype0       <= req_pc + 32'd4;
                Instraction_pype <= imem.imem_rdata;
                fetch_valid      <= 1'b1;
            end else begin
                Instraction_pype <= NOP_INSN;
                fetch_valid      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table-driven streaming/stall vectors plus
// hand sequences for redirect and mid-operation reset.
import rv_pipe_pkg::*;

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        keep;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype;
    logic        fetch_valid;

    fetch_stage_if mif ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .keep             (keep),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .imem             (mif),
        .PC_pype0         (PC_pype0),
        .PCp4_pype0       (PCp4_pype0),
        .Instraction_pype (Instraction_pype),
        .fetch_valid      (fetch_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        keep;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_pcp4;
        logic [31:0] exp_insn;
        logic        exp_valid;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cnum = 0;
    int          lat = 1;
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] q_addr[$];
    int          q_due[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] epc, input logic [31:0] epc4,
                           input logic [31:0] einsn, input logic evld);
        chk({name, ".pc"}, PC_pype0, epc);
        chk({name, ".pcp4"}, PCp4_pype0, epc4);
        chk({name, ".insn"}, Instraction_pype, einsn);
        chk({name, ".valid"}, {31'h0, fetch_valid}, {31'h0, evld});
    endtask

    // One clock: sample the request mid-cycle, then model the memory after the edge.
    task automatic cyc();
        @(negedge clk);
        s_req  = mif.imem_req;
        s_addr = mif.imem_addr;
        @(posedge clk);
        #1;
        cnum++;
        if (s_req && mif.imem_ack) begin
            q_addr.push_back(s_addr);
            q_due.push_back(cnum + lat - 1);
        end
        if (q_addr.size() > 0 && q_due[0] == cnum) begin
            mif.imem_rvalid = 1'b1;
            mif.imem_rdata  = mem_data(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            mif.imem_rvalid = 1'b0;
            mif.imem_rdata  = 32'h0;
        end
    endtask

    vec_t tbl[10];

    initial begin
        bit found;
        int k;
        logic [31:0] N;
        N = NOP_INSN;

        //            keep req addr       pc         pcp4       insn            valid
        tbl[0] = '{1'b0, 1'b1, 32'h00, 32'h00, 32'h00, N,              1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h04, 32'h00, 32'h04, 32'hA5A5_0000,  1'b1};
        tbl[2] = '{1'b0, 1'b1, 32'h08, 32'h04, 32'h08, 32'hA5A5_0004,  1'b1};
        tbl[3] = '{1'b1, 1'b0, 32'h00, 32'h04, 32'h08, 32'hA5A5_0004,  1'b1};
        tbl[4] = '{1'b1, 1'b0, 32'h00, 32'h04, 32'h08, 32'hA5A5_0004,  1'b1};
        tbl[5] = '{1'b1, 1'b0, 32'h00, 32'h04, 32'h08, 32'hA5A5_0004,  1'b1};
        tbl[6] = '{1'b0, 1'b0, 32'h00, 32'h08, 32'h0C, 32'hA5A5_0008,  1'b1};
        tbl[7] = '{1'b0, 1'b1, 32'h0C, 32'h08, 32'h0C, N,              1'b0};
        tbl[8] = '{1'b0, 1'b1, 32'h10, 32'h0C, 32'h10, 32'hA5A5_000C,  1'b1};
        tbl[9] = '{1'b0, 1'b1, 32'h14, 32'h10, 32'h14, 32'hA5A5_0010,  1'b1};

        rst = 1'b1; keep = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mif.imem_ack = 1'b1; mif.imem_rvalid = 1'b0; mif.imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 32'h0, 32'h0, N, 1'b0);
        chk("reset.req", {31'h0, mif.imem_req}, 32'h0);
        rst = 1'b0;

        // Streaming with 1-cycle memory, then a 3-cycle keep over the 0x8 response.
        for (int i = 0; i < 10; i++) begin
            keep = tbl[i].keep;
            cyc();
            chk($sformatf("vec%0d.req", i), {31'h0, s_req}, {31'h0, tbl[i].exp_req});
            if (tbl[i].exp_req)
                chk($sformatf("vec%0d.addr", i), s_addr, tbl[i].exp_addr);
            chk_out($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_pcp4,
                    tbl[i].exp_insn, tbl[i].exp_valid);
        end
        keep = 1'b0;

        // Redirect to 0x100 while the 0x20 fetch is outstanding (3-cycle memory).
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (s_req && s_addr == 32'h20) found = 1'b1;
        end
        chk("redir.reach20", {31'h0, found}, 32'h1);
        redirect = 1'b1; redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        chk("redir.noreq", {31'h0, s_req}, 32'h0);
        chk_out("redir.bubble", 32'h1C, 32'h20, N, 1'b0);
        k = 0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if (s_req) found = 1'b1; else k++;
            chk($sformatf("redir.drop%0d", i), {31'h0, fetch_valid}, 32'h0);
        end
        chk("redir.req_found", {31'h0, found}, 32'h1);
        chk("redir.req_delay", k, 2);
        chk("redir.target", s_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if (fetch_valid) found = 1'b1;
        end
        chk("redir.resp_found", {31'h0, found}, 32'h1);
        chk_out("redir.first", 32'h100, 32'h104, 32'hA5A5_0100, 1'b1);

        // Redirect in the same cycle as a response: the response is discarded.
        found = mif.imem_rvalid;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if (mif.imem_rvalid) found = 1'b1;
        end
        chk("samecyc.rvalid_seen", {31'h0, found}, 32'h1);
        redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect = 1'b0;
        chk("samecyc.noreq", {31'h0, s_req}, 32'h0);
        chk_out("samecyc.bubble", 32'h100, 32'h104, N, 1'b0);
        lat = 1;
        cyc();
        chk("samecyc.req", {31'h0, s_req}, 32'h1);
        chk("samecyc.target", s_addr, 32'h200);

        // Redirect while keep holds a full hold buffer.
        cyc();
        chk("hold.req204", s_addr, 32'h204);
        chk_out("hold.out200", 32'h200, 32'h204, 32'hA5A5_0200, 1'b1);
        keep = 1'b1;
        cyc();
        chk("hold.noreq", {31'h0, s_req}, 32'h0);
        chk_out("hold.keep", 32'h200, 32'h204, 32'hA5A5_0200, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h300;
        cyc();
        chk("hold.redir_noreq", {31'h0, s_req}, 32'h0);
        chk_out("hold.bubble", 32'h200, 32'h204, N, 1'b0);
        redirect = 1'b0; keep = 1'b0;
        cyc();
        chk("hold.req", {31'h0, s_req}, 32'h1);
        chk("hold.target", s_addr, 32'h300);
        chk_out("hold.cleared", 32'h200, 32'h204, N, 1'b0);
        cyc();
        chk("hold.req304", s_addr, 32'h304);
        chk_out("hold.first", 32'h300, 32'h304, 32'hA5A5_0300, 1'b1);

        // Reset with a request outstanding, then a stale rvalid after release.
        lat = 3;
        rst = 1'b1;
        #1;
        chk_out("midrst", 32'h0, 32'h0, N, 1'b0);
        chk("midrst.req", {31'h0, mif.imem_req}, 32'h0);
        q_addr.delete(); q_due.delete();
        mif.imem_rvalid = 1'b0;
        cyc();
        rst = 1'b0;
        mif.imem_rvalid = 1'b1; mif.imem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("midrst.req0", {31'h0, s_req}, 32'h1);
        chk("midrst.addr0", s_addr, 32'h0);
        chk_out("midrst.stale", 32'h0, 32'h0, N, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if (fetch_valid) found = 1'b1;
        end
        chk("midrst.resp_found", {31'h0, found}, 32'h1);
        chk_out("midrst.first", 32'h0, 32'h4, 32'hA5A5_0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
